// File: rtl/spi_xfer_arbiter_if.sv
// Handshake bundle between on-chip requesters, the arbiter and a 12-bit SPI master.
//
// Modports:
//   master - the arbiter's view: it consumes requests and master completions, and drives
//            acks, response data, the master launch controls and the slave selects.
//   slave  - the environment's view: requesters and the SPI master model.
//
// Signals:
//   req      [NUM_REQ]        per-requester transfer request (level)
//   req_data [NUM_REQ*DATA_W] transmit words, requester i at [i*DATA_W +: DATA_W]
//   ack      [NUM_REQ]        one-hot, one-cycle completion pulse
//   rsp_data [DATA_W]         received word, valid with ack
//   rsp_err                   timeout flag, valid with ack
//   m_start                   one-cycle launch pulse to the SPI master
//   m_din    [DATA_W]         word the master shifts out
//   m_done                    one-cycle completion pulse from the master
//   m_dout   [DATA_W]         word the master shifted in, valid with m_done
//   ss_n     [NUM_REQ]        active-low slave selects, at most one low
//   busy                      high whenever the arbiter is not idle
interface spi_xfer_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 12
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      m_start;
  logic [DATA_W-1:0]         m_din;
  logic                      m_done;
  logic [DATA_W-1:0]         m_dout;
  logic [NUM_REQ-1:0]        ss_n;
  logic                      busy;

  modport master (
    input  req, req_data, m_done, m_dout,
    output ack, rsp_data, rsp_err, m_start, m_din, ss_n, busy
  );

  modport slave (
    output req, req_data, m_done, m_dout,
    input  ack, rsp_data, rsp_err, m_start, m_din, ss_n, busy
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master among NUM_REQ requesters.
//
// A request seen in idle is granted by round-robin starting after the last served
// requester; its word is latched into m_din and its slave select is pulled low. The master
// is launched with a one-cycle m_start, the received word is captured on m_done, and the
// requester gets a one-cycle ack. All slave selects then stay high for at least GAP_CYCLES
// cycles before the next grant.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - spi_xfer_arbiter_if.master (requests, acks, master launch/completion, ss_n, busy)
//
// Build option:
//   SPI_ARB_TIMEOUT_EN - when defined, a watchdog ends a WAIT that lasts TIMEOUT_CYCLES
//                        cycles without m_done, returning rsp_err=1 and rsp_data=0. When
//                        undefined, rsp_err is tied low and WAIT waits indefinitely.
module spi_xfer_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst,
  spi_xfer_arbiter_if.master bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IdxW-1:0]    LastRst = IdxW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StResp, StGap} state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_grant;
  logic [IdxW-1:0]     r_last;
  logic [GapW-1:0]     r_gap_cnt;
  logic [NUM_REQ-1:0]  r_ss_n;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_m_start;
  logic                r_busy;
  logic [DATA_W-1:0]   r_m_din;
  logic [DATA_W-1:0]   r_rsp_data;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] r_to_cnt;
  logic           r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Round-robin pick: scan offsets 1..NUM_REQ from the last served requester and take the
  // first one requesting.
  logic              w_any_req;
  logic [IdxW-1:0]   w_win_idx;
  logic [DATA_W-1:0] w_win_data;

  always_comb begin
    w_any_req  = 1'b0;
    w_win_idx  = '0;
    w_win_data = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_any_req && bus.req[i] && ((32'(r_last) + k) % NUM_REQ == i)) begin
          w_any_req  = 1'b1;
          w_win_idx  = IdxW'(i);
          w_win_data = bus.req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_last     <= LastRst;
      r_gap_cnt  <= '0;
      r_ss_n     <= '1;
      r_ack      <= '0;
      r_m_start  <= 1'b0;
      r_busy     <= 1'b0;
      r_m_din    <= '0;
      r_rsp_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; states that need them assert for exactly one cycle.
      r_m_start <= 1'b0;
      r_ack     <= '0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_grant <= w_win_idx;
            r_m_din <= w_win_data;
            r_ss_n  <= ~(OneHot0 << w_win_idx);
            r_busy  <= 1'b1;
            r_state <= StLaunch;
          end
        end
        StLaunch: begin
          r_m_start <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          r_to_cnt  <= '0;
`endif
          r_state   <= StWait;
        end
        StWait: begin
`ifdef SPI_ARB_TIMEOUT_EN
          // m_done takes priority over a watchdog expiring in the same cycle.
          if (bus.m_done) begin
            r_rsp_data <= bus.m_dout;
            r_rsp_err  <= 1'b0;
            r_state    <= StResp;
          end else if (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= StResp;
          end else begin
            r_to_cnt <= r_to_cnt + ToW'(1);
          end
`else
          if (bus.m_done) begin
            r_rsp_data <= bus.m_dout;
            r_state    <= StResp;
          end
`endif
        end
        StResp: begin
          r_ack     <= OneHot0 << r_grant;
          r_ss_n    <= '1;
          r_last    <= r_grant;
          r_gap_cnt <= '0;
          r_state   <= StGap;
        end
        StGap: begin
          if (r_gap_cnt == GapW'(GAP_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt + GapW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.rsp_data = r_rsp_data;
  assign bus.m_start  = r_m_start;
  assign bus.m_din    = r_m_din;
  assign bus.ss_n     = r_ss_n;
  assign bus.busy     = r_busy;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.rsp_err  = r_rsp_err;
`else
  assign bus.rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: directed cases plus randomized request
// traffic checked against a transaction-level round-robin model.
module tb_spi_xfer_arbiter;

  localparam int unsigned NumReq        = 4;
  localparam int unsigned DataW         = 12;
  localparam int unsigned GapCycles     = 2;
  localparam int unsigned TimeoutCycles = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   m_last;
  logic [DataW-1:0] m_data [NumReq];
  logic [NumReq-1:0] all_high;

  spi_xfer_arbiter_if #(.NUM_REQ(NumReq), .DATA_W(DataW)) bus ();

  spi_xfer_arbiter #(
    .NUM_REQ       (NumReq),
    .DATA_W        (DataW),
    .GAP_CYCLES    (GapCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Round-robin reference: first requester found scanning from last+1 with wrap.
  function automatic int rr_pick(input int last, input logic [NumReq-1:0] r);
    for (int k = 1; k <= NumReq; k++) begin
      int idx;
      idx = (last + k) % NumReq;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NumReq-1:0] v);
    for (int i = 0; i < NumReq; i++) if (v == (NumReq'(1) << i)) return i;
    return -1;
  endfunction

  task automatic raise(input int i, input logic [DataW-1:0] d);
    m_data[i] = d;
    bus.req[i] = 1'b1;
    bus.req_data[i*DataW +: DataW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.m_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ss_n", bus.ss_n, all_high);
    check("reset_busy", bus.busy, 0);
    check("reset_ack", bus.ack, 0);
    check("reset_m_start", bus.m_start, 0);
    check("reset_m_din", bus.m_din, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    m_last = NumReq - 1;
  endtask

  // Waits for the grant; returns 1 when busy rose within the budget.
  task automatic wait_grant(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b1 && n < 20);
    ok = (bus.busy === 1'b1);
    if (!ok) check("grant_seen", bus.busy, 1);
  endtask

  // Entered right after the ack cycle; a stray m_done is injected and must be ignored.
  task automatic finish_gap(input logic [DataW-1:0] exp_rsp);
    int n, bad;
    n = 1;
    bad = 0;
    bus.m_done = 1'b1;
    bus.m_dout = DataW'($urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.m_done = 1'b0;
      if (bus.busy !== 1'b1) break;
      n++;
      if (bus.ss_n !== all_high || bus.ack !== '0) bad++;
    end
    check("gap_len", n, GapCycles);
    check("gap_quiet", bad, 0);
    check("idle_ss_n", bus.ss_n, all_high);
    check("rsp_hold", bus.rsp_data, exp_rsp);
  endtask

  // One full transaction; caller sets req at an idle negedge, then calls immediately.
  task automatic do_xfer(input int delay, input logic [DataW-1:0] dout, output int win);
    int exp_w, bad_ss, bad_start;
    bit ok;
    logic [NumReq-1:0] exp_ss;
    win = -1;
    exp_w = rr_pick(m_last, bus.req);
    if (exp_w < 0) return;
    wait_grant(ok);
    if (!ok) return;
    exp_ss = ~(NumReq'(1) << exp_w);
    check("grant_ss_n", bus.ss_n, exp_ss);
    check("grant_m_din", bus.m_din, m_data[exp_w]);
    check("grant_no_start", bus.m_start, 0);
    @(negedge clk);
    check("m_start", bus.m_start, 1);
    bad_ss = 0;
    bad_start = 0;
    repeat (delay) begin
      @(negedge clk);
      if (bus.ss_n !== exp_ss) bad_ss++;
      if (bus.m_start !== 1'b0 || bus.ack !== '0) bad_start++;
    end
    bus.m_done = 1'b1;
    bus.m_dout = dout;
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_dout = DataW'($urandom);
    check("wait_ss_n_stable", bad_ss, 0);
    check("single_m_start", bad_start, 0);
    check("resp_ss_n_low", bus.ss_n, exp_ss);
    check("resp_no_ack_yet", bus.ack, 0);
    @(negedge clk);
    check("ack", bus.ack, NumReq'(1) << exp_w);
    check("rsp_data", bus.rsp_data, dout);
    check("rsp_err", bus.rsp_err, 0);
    check("ack_ss_n_high", bus.ss_n, all_high);
    win = onehot_idx(bus.ack);
    m_last = exp_w;
    bus.req[exp_w] = 1'b0;
    finish_gap(dout);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic do_timeout(input bit with_done, input logic [DataW-1:0] dout);
    int exp_w, early;
    bit ok;
    exp_w = rr_pick(m_last, bus.req);
    if (exp_w < 0) return;
    wait_grant(ok);
    if (!ok) return;
    @(negedge clk);
    check("to_m_start", bus.m_start, 1);
    early = 0;
    for (int k = 1; k <= TimeoutCycles; k++) begin
      @(negedge clk);
      bus.m_done = 1'b0;
      if (bus.ack !== '0) early++;
      // Lands on the edge where the watchdog expires.
      if (with_done && k == TimeoutCycles - 1) begin
        bus.m_done = 1'b1;
        bus.m_dout = dout;
      end
    end
    @(negedge clk);
    check("to_no_early_ack", early, 0);
    check("to_ack", bus.ack, NumReq'(1) << exp_w);
    check("to_rsp_err", bus.rsp_err, with_done ? 0 : 1);
    check("to_rsp_data", bus.rsp_data, with_done ? dout : 0);
    check("to_ss_n", bus.ss_n, all_high);
    m_last = exp_w;
    bus.req[exp_w] = 1'b0;
    finish_gap(with_done ? dout : '0);
  endtask
`endif

  initial begin
    int w;
    int hog_exp [4];
    bit ok;
    hog_exp = '{2, 2, 1, 2};
    all_high = '1;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.m_done = 1'b0;
    bus.m_dout = '0;
    do_reset();

    // Single transfer.
    raise(0, 12'hA5C);
    do_xfer(20, 12'h3F1, w);
    check("single_winner", w, 0);

    // Round-robin fairness with everybody requesting.
    do_reset();
    for (int i = 0; i < NumReq; i++) raise(i, DataW'($urandom));
    for (int t = 0; t < 6; t++) begin
      do_xfer($urandom_range(1, 6), DataW'($urandom), w);
      check("rr_order", w, t % NumReq);
      if (w >= 0) raise(w, DataW'($urandom));
    end

    // Withdrawn before grant: never served.
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("withdrawn_no_grant", bus.busy, 0);

    // Hogger, then requester 1 joins.
    for (int t = 0; t < 4; t++) begin
      if (t < 3) raise(2, DataW'($urandom));
      if (t == 2) raise(1, DataW'($urandom));
      do_xfer($urandom_range(1, 5), DataW'($urandom), w);
      check("hog_order", w, hog_exp[t]);
    end

    // Reset in the middle of WAIT.
    raise(0, DataW'($urandom));
    wait_grant(ok);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ss_n", bus.ss_n, all_high);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ack", bus.ack, 0);
    @(negedge clk);
    check("midrst_no_ack", bus.ack, 0);
    rst = 1'b0;
    m_last = NumReq - 1;
    do_xfer(3, DataW'($urandom), w);
    check("midrst_regrant", w, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NumReq; i++)
        if (!bus.req[i] && $urandom_range(0, 2) == 0) raise(i, DataW'($urandom));
      if ($urandom_range(0, 4) == 0) bus.req[$urandom_range(0, NumReq - 1)] = 1'b0;
      if (bus.req == '0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("rand_idle", bus.busy, 0);
        raise($urandom_range(0, NumReq - 1), DataW'($urandom));
      end
      do_xfer($urandom_range(1, 8), DataW'($urandom), w);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    bus.req = '0;
    raise(3, DataW'($urandom));
    do_timeout(1'b0, '0);
    raise(1, DataW'($urandom));
    do_timeout(1'b1, 12'h5A7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin arbiter and sequencer that shares one 12-bit SPI master among up to `NUM_REQ` requesters, each owning a dedicated active-low slave-select line. It latches a winning requester's transmit word, launches the master, and returns the received word with a one-cycle acknowledge. It enforces a minimum chip-select-high gap between consecutive transactions. It sits between on-chip clients and the SPI master, and drives the slave-select lines seen by the SPI slaves.

## Interface
- `NUM_REQ`, default 4: number of requesters and slave-select lines (2..8).
- `DATA_W`, default 12: SPI word width.
- `GAP_CYCLES`, default 2: minimum cycles all `ss_n` stay high between transactions (≥1).
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in the WAIT state (used only when `SPI_ARB_TIMEOUT_EN` is defined).

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: per-requester transfer request (level).
- `req_data` in NUM_REQ*DATA_W: transmit words; requester i occupies bits [i*DATA_W +: DATA_W].
- `ack` out NUM_REQ: one-hot, one-cycle completion pulse.
- `rsp_data` out DATA_W: received word; valid while `ack` is nonzero.
- `rsp_err` out 1: timeout flag; valid while `ack` is nonzero.
- `m_start` out 1: one-cycle start pulse to the SPI master.
- `m_din` out DATA_W: word for the master to transmit; held stable from `m_start` until `m_done`.
- `m_done` in 1: one-cycle completion pulse from the master.
- `m_dout` in DATA_W: word received by the master; valid when `m_done` is high.
- `ss_n` out NUM_REQ: active-low slave selects; at most one bit is low at any time.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP, GAP.
- **IDLE:** if any `req` bit is high, choose the winner by round-robin.
  - Search order starts at `last+1` (mod NUM_REQ) and wraps; `last` resets to NUM_REQ-1, so requester 0 wins first after reset.
  - Register the grant index, latch its `req_data` into `m_din`, drive its `ss_n` bit low, and go to LAUNCH.
- **LAUNCH:** pulse `m_start` for one cycle, then go to WAIT.
- **WAIT:** on `m_done`, capture `m_dout` into `rsp_data`, clear `rsp_err`, and go to RESP.
- **RESP:**
  - Pulse `ack[grant]` for one cycle, drive `ss_n` all high, and set `last` to the grant index.
  - `rsp_data` and `rsp_err` hold their values until the next RESP.
  - Go to GAP.
- **GAP:** count GAP_CYCLES cycles with `ss_n` all high, then return to IDLE.
- **Requester rules:**
  - Keep `req` high and `req_data` stable until `ack` is seen.
  - Deassert `req` in the cycle after `ack`. A `req` still high in IDLE starts a new transfer.
  - `req_data` is sampled once, in IDLE at the grant. Changes after that are ignored.
- **Request withdrawn:**
  - A `req` dropped after the grant does not abort the transfer; the transfer completes and `ack` still pulses.
  - A `req` dropped before the grant is never served.
- **Ignored inputs:** `m_done` is ignored outside WAIT.
- **Reset (any time, including mid-transfer):** the FSM goes to IDLE immediately.
  - `ss_n` goes all high asynchronously.
  - `m_start`, `ack`, `rsp_err`, `busy` = 0; `m_din` and `rsp_data` = 0; `last` = NUM_REQ-1; gap and timeout counters = 0.

## Timing
- Request seen high in IDLE at edge N:
  - `ss_n[i]` goes low and `busy` goes high after edge N.
  - `m_start` is high for the cycle after edge N+1.
- `m_done` sampled at edge M: `ack` and `rsp_data` are valid after edge M+1.
- `ss_n` stays low from the grant through the WAIT cycle that sees `m_done`, and rises with `ack`.
- Minimum between-transaction overhead: GAP_CYCLES plus one IDLE evaluation cycle.
- Idle-to-start latency: 2 cycles.
- Completion latency: 1 cycle after `m_done`.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments in every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without `m_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - If `m_done` and the timeout expire in the same cycle, `m_done` wins: `rsp_err`=0 and the data is captured.
- **Not defined:** there is no counter, `rsp_err` is constant 0, and WAIT waits for `m_done` indefinitely.

## Test plan
- **Single transfer:**
  - Stimulus: `req`=0001, `req_data[0]`=0xA5C; the master model returns 0x3F1 with `m_done` 20 cycles after `m_start`.
  - Required: `m_din`=0xA5C; one `m_start` pulse; `ss_n`=1110 throughout the transfer; `ack`=0001 with `rsp_data`=0x3F1, `rsp_err`=0.
- **Round-robin fairness:**
  - Stimulus: `req`=1111 held, with each requester re-raising `req` after its ack.
  - Required: grant order 0,1,2,3,0,1; `ss_n` goes all high for ≥GAP_CYCLES between grants.
- **Single hogger:**
  - Stimulus: `req`=0100 held continuously, then requester 1 joins.
  - Required: the grant after the current one goes to 1, then back to 2.
- **Mid-transfer reset:**
  - Stimulus: assert `rst` in WAIT.
  - Required: `ss_n`=1111 and `busy`=0 in the same cycle, with no `ack`.
  - After release, with `req`=0001: the grant goes to requester 0.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):**
  - Stimulus: the master never sends `m_done`.
  - Required: `ack` pulses 17 cycles after entering WAIT, with `rsp_err`=1 and `rsp_data`=0; `ss_n` is all high.
- **Simultaneous `m_done` and timeout expiry:**
  - Stimulus: `m_done` arrives in the same cycle the timeout expires.
  - Required: `rsp_err`=0 and `rsp_data` equals `m_dout`.
